delay_arb_ctrl: RTL and testbench

DELAY_ARB_CTRL -- requirements
Module: delay_arb_ctrl

---
 rtl/delay_arb_ctrl.sv | 175 +++++++++++++++++
 tb/tb_delay_arb_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/delay_arb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : delay_arb_ctrl
// Purpose  : Round-robin arbiter that lets NREQ 4-phase bundled-data
//            requesters share one matched-delay resource. The winner's data
//            is registered onto data_out, the downstream request is raised
//            after a counted delay, and the 4-phase handshake is relayed
//            back to the winning requester.
// Ports    : clk       - single clock, rising edge
//            rst       - synchronous active-high reset
//            req_in    - per-requester 4-phase request            [NREQ]
//            data_in   - bundled data, slice k for requester k    [NREQ*WIDTH]
//            ack_in    - per-requester 4-phase acknowledge        [NREQ]
//            req_out   - downstream request after matched delay
//            data_out  - registered data of the granted requester [WIDTH]
//            ack_out   - downstream acknowledge
//            grant     - one-hot owner, zero when idle            [NREQ]
//            delay_cfg - per-transaction delay (only with DELAY_PROG_EN)
// Options  : DELAY_PROG_EN - when defined, adds delay_cfg, sampled at grant;
//                            0 is treated as 1.
// Revision : 1.0 - initial release
// ============================================================================
module delay_arb_ctrl #(
    parameter int NREQ  = 2,
    parameter int WIDTH = 8,
    parameter int DELAY = 4,
    parameter int CW    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_in,
    input  logic [NREQ*WIDTH-1:0] data_in,
    output logic [NREQ-1:0]       ack_in,
    output logic                  req_out,
    output logic [WIDTH-1:0]      data_out,
    input  logic                  ack_out,
`ifdef DELAY_PROG_EN
    input  logic [CW-1:0]         delay_cfg,
`endif
    output logic [NREQ-1:0]       grant
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DELAY = 3'd1,
        S_OUT   = 3'd2,
        S_ACK   = 3'd3,
        S_RTZ   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              req_out_q, req_out_d;

    logic [NREQ-1:0]   w_elig;
    logic [NREQ-1:0]   w_upper;
    logic [PW-1:0]     w_win_idx;
    logic              w_win_vld;
    logic [CW-1:0]     w_load_val;

    // Only IDLE looks at eligibility, and ack_in is zero there, but keeping
    // the mask makes the intent explicit.
    assign w_elig = req_in & ~ack_in;

    // Round-robin: prefer the lowest eligible index at or above the pointer,
    // otherwise wrap around to the lowest eligible index overall.
    always_comb begin
        logic found;
        w_upper   = '0;
        w_win_idx = '0;
        found     = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            w_upper[i] = w_elig[i] && (i >= int'(ptr_q));
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && w_upper[i]) begin
                w_win_idx = PW'(i);
                found     = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && w_elig[i]) begin
                w_win_idx = PW'(i);
                found     = 1'b1;
            end
        end
        w_win_vld = |w_elig;
    end

`ifdef DELAY_PROG_EN
    assign w_load_val = (delay_cfg == '0) ? CW'(1) : delay_cfg;
`else
    assign w_load_val = CW'(DELAY);
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        data_d    = data_q;
        req_out_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_win_vld) begin
                    grant_d = NREQ'(1) << w_win_idx;
                    data_d  = data_in[w_win_idx*WIDTH +: WIDTH];
                    cnt_d   = w_load_val;
                    ptr_d   = (w_win_idx == PW'(NREQ-1)) ? '0 : w_win_idx + 1'b1;
                    state_d = S_DELAY;
                end
            end
            S_DELAY: begin
                // ack_out here is a downstream protocol error and is ignored.
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= CW'(1)) begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                // req_out is registered, so it becomes visible one cycle after
                // entering OUT; an ack seen before req_out is visible cannot
                // belong to this request and is ignored.
                if (ack_out && req_out_q) begin
                    state_d = S_ACK;
                end else begin
                    req_out_d = 1'b1;
                end
            end
            S_ACK: begin
                if (!(|(req_in & grant_q)) && !ack_out) begin
                    grant_d = '0;
                    state_d = S_RTZ;
                end
            end
            S_RTZ: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            ptr_q     <= '0;
            grant_q   <= '0;
            data_q    <= '0;
            req_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            data_q    <= data_d;
            req_out_q <= req_out_d;
        end
    end

    assign ack_in   = (state_q == S_ACK) ? grant_q : '0;
    assign req_out  = req_out_q;
    assign data_out = data_q;
    assign grant    = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_delay_arb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_delay_arb_ctrl
// Purpose  : Self-checking bench for delay_arb_ctrl. Random 4-phase traffic
//            is checked against a transaction-level model (pending mask,
//            round-robin pointer, expected delay). Honours DELAY_PROG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_delay_arb_ctrl;

    localparam int NREQ  = 3;
    localparam int WIDTH = 8;
    localparam int DELAY = 4;
    localparam int CW    = 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_in;
    logic [NREQ*WIDTH-1:0] data_in;
    logic [NREQ-1:0]       ack_in;
    logic                  req_out;
    logic [WIDTH-1:0]      data_out;
    logic                  ack_out;
    logic [NREQ-1:0]       grant;
`ifdef DELAY_PROG_EN
    logic [CW-1:0]         delay_cfg;
`endif

    always #5 clk = ~clk;

    delay_arb_ctrl #(
        .NREQ (NREQ),
        .WIDTH(WIDTH),
        .DELAY(DELAY),
        .CW   (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_in   (req_in),
        .data_in  (data_in),
        .ack_in   (ack_in),
        .req_out  (req_out),
        .data_out (data_out),
        .ack_out  (ack_out),
`ifdef DELAY_PROG_EN
        .delay_cfg(delay_cfg),
`endif
        .grant    (grant)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    int              ptr;
    logic [NREQ-1:0] pend;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
        for (int i = 0; i < NREQ; i++) begin
            int k;
            k = (p + i) % NREQ;
            if (r[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int k);
        logic [NREQ-1:0] v;
        v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    // Raise idle requesters at random, each with fresh bundled data.
    task automatic raise_random;
        for (int k = 0; k < NREQ; k++) begin
            if (!pend[k] && ($urandom % 2 == 1)) begin
                data_in[k*WIDTH +: WIDTH] = WIDTH'($urandom);
                pend[k] = 1'b1;
            end
        end
        req_in = pend;
    endtask

    task automatic run_txn;
        int               w;
        int               d_eff;
        int               n;
        logic [WIDTH-1:0] exp_data;

        if (pend == '0) begin
            tick;
            chk("idle_grant", 64'(grant), 64'(0));
            raise_random;
            return;
        end

        w        = rr_pick(pend, ptr);
        exp_data = data_in[w*WIDTH +: WIDTH];
`ifdef DELAY_PROG_EN
        delay_cfg = CW'($urandom_range(0, 5));
        d_eff     = (delay_cfg == 0) ? 1 : int'(delay_cfg);
`else
        d_eff     = DELAY;
`endif
        tick;  // arbitration edge
        chk("grant", 64'(grant), 64'(onehot(w)));
        chk("grant_data", 64'(data_out), 64'(exp_data));
        chk("grant_req_out", 64'(req_out), 64'(0));
        ptr = (w + 1) % NREQ;
`ifdef DELAY_PROG_EN
        delay_cfg = CW'($urandom);  // only the value at grant matters
`endif

        // Winner may withdraw its request early; transaction must continue.
        if ($urandom % 4 == 0) begin
            pend[w] = 1'b0;
            data_in[w*WIDTH +: WIDTH] = WIDTH'($urandom);
        end
        raise_random;  // newcomers are held pending

        for (int k = 1; k <= d_eff; k++) begin
            ack_out = 1'($urandom % 2);  // stray ack during DELAY
            tick;
            chk("delay_req_out", 64'(req_out), 64'(0));
            chk("delay_ack_in", 64'(ack_in), 64'(0));
        end
        ack_out = 1'b0;
        tick;
        chk("req_out_rise", 64'(req_out), 64'(1));
        chk("out_grant", 64'(grant), 64'(onehot(w)));
        chk("out_data", 64'(data_out), 64'(exp_data));

        n = $urandom % 3;
        for (int k = 0; k < n; k++) begin
            tick;
            chk("out_hold", 64'(req_out), 64'(1));
        end

        ack_out = 1'b1;
        tick;
        chk("ack_req_out", 64'(req_out), 64'(0));
        chk("ack_in", 64'(ack_in), 64'(onehot(w)));
        if ($urandom % 2 == 1) begin
            tick;
            chk("ack_hold", 64'(ack_in), 64'(onehot(w)));
        end

        ack_out = 1'b0;
        pend[w] = 1'b0;
        req_in  = pend;
        tick;
        chk("rtz_ack_in", 64'(ack_in), 64'(0));
        chk("rtz_grant", 64'(grant), 64'(0));
        chk("rtz_data", 64'(data_out), 64'(exp_data));
        raise_random;
        tick;  // back to IDLE, no arbitration on this edge
        chk("idle_entry_grant", 64'(grant), 64'(0));
    endtask

    initial begin
        rst     = 1'b1;
        req_in  = '0;
        data_in = '0;
        ack_out = 1'b0;
`ifdef DELAY_PROG_EN
        delay_cfg = '0;
`endif
        tick;
        tick;
        chk("rst_grant", 64'(grant), 64'(0));
        chk("rst_ack_in", 64'(ack_in), 64'(0));
        chk("rst_req_out", 64'(req_out), 64'(0));
        chk("rst_data", 64'(data_out), 64'(0));

        rst  = 1'b0;
        ptr  = 0;
        data_in[0*WIDTH +: WIDTH] = 8'hA5;
        data_in[1*WIDTH +: WIDTH] = 8'h3C;
        pend   = 3'b011;
        req_in = pend;

        for (int t = 0; t < 40; t++) begin
            run_txn;
        end

        // Reset in the middle of a DELAY phase.
        while (pend == '0) raise_random;
        begin
            int w;
            w = rr_pick(pend, ptr);
`ifdef DELAY_PROG_EN
            delay_cfg = CW'(5);
`endif
            tick;
            chk("mid_grant", 64'(grant), 64'(onehot(w)));
        end
        tick;
        tick;
        rst    = 1'b1;
        pend   = '0;
        req_in = '0;
        tick;
        chk("mid_rst_grant", 64'(grant), 64'(0));
        chk("mid_rst_ack_in", 64'(ack_in), 64'(0));
        chk("mid_rst_req_out", 64'(req_out), 64'(0));
        chk("mid_rst_data", 64'(data_out), 64'(0));
        rst = 1'b0;
        ptr = 0;
        for (int k = 0; k < 8; k++) begin
            tick;
            chk("post_rst_req_out", 64'(req_out), 64'(0));
        end
        // Pointer restarts at 0 after reset.
        pend   = 3'b110;
        req_in = pend;
        tick;
        chk("post_rst_rr", 64'(grant), 64'(onehot(rr_pick(3'b110, 0))));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
